// File: rtl/gpio_input_port.sv
// gpio_input_port: memory-mapped GPIO input peripheral.
// Pins pass through a two-flop synchronizer and an optional debounce filter, then an
// edge detector. Detected edges land in sticky write-1-to-clear STATUS bits. A level irq
// is raised while any STATUS bit is unmasked.
// Register map (word index): 0 DATA (RO, filtered level), 1 MASK (RW), 2 STATUS (W1C),
// 3 EDGE_SEL (RW, 0 = rising edge, 1 = falling edge).
// Build option: define DEBOUNCE_EN to add a per-pin debounce filter of DEB_CYCLES cycles.
module gpio_input_port #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins,
  input  logic             bus_sel,
  input  logic [1:0]       bus_addr,
  input  logic             bus_we,
  input  logic             bus_rd,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_MASK     = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] status_reg;
  logic [WIDTH-1:0] status_next;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] edge_sel_reg;
  logic [WIDTH-1:0] edge_evt;
  logic [31:0]      rdata_reg;
  logic [31:0]      rdata_next;
  logic             irq_reg;

  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wr_bits;
  logic             unused_wdata_bits;

  assign wr_en   = bus_sel & bus_we;
  assign rd_en   = bus_sel & bus_rd;
  assign wr_bits = bus_wdata[WIDTH-1:0];
  // Upper write-data bits have no storage behind them.
  assign unused_wdata_bits = ^bus_wdata;

  // Two-flop synchronizer; nothing sits between the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= pins;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [CW-1:0] count_reg;
      logic          filt_bit_reg;

      // The filtered level only follows sync2 after it has disagreed for DEB_CYCLES
      // consecutive cycles; any agreement restarts the count, dropping short glitches.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_reg    <= '0;
          filt_bit_reg <= 1'b0;
        end else if (sync2_reg[gi] == filt_bit_reg) begin
          count_reg <= '0;
        end else if (count_reg == CW'(DEB_CYCLES - 1)) begin
          filt_bit_reg <= sync2_reg[gi];
          count_reg    <= '0;
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end

      assign filt[gi] = filt_bit_reg;
    end
  endgenerate
`else
  localparam int deb_cycles_unused = DEB_CYCLES;

  assign filt = sync2_reg;
`endif

  // prev is filt one cycle late, so events come only from real filt transitions and a
  // change of EDGE_SEL alone can never create one.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= filt;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign edge_evt[gi] = edge_sel_reg[gi] ? (~filt[gi] &  prev_reg[gi])
                                             : ( filt[gi] & ~prev_reg[gi]);
    end
  endgenerate

  // Sticky status: a write of 1 clears, but a same-cycle event wins over the clear.
  always_comb begin
    status_next = status_reg;
    if (wr_en && (bus_addr == ADDR_STATUS)) begin
      status_next = status_next & ~wr_bits;
    end
    status_next = status_next | edge_evt;
  end

  // Read mux samples current register state; result is held until the next read.
  always_comb begin
    rdata_next = rdata_reg;
    if (rd_en) begin
      rdata_next = '0;
      case (bus_addr)
        ADDR_DATA:     rdata_next[WIDTH-1:0] = filt;
        ADDR_MASK:     rdata_next[WIDTH-1:0] = mask_reg;
        ADDR_STATUS:   rdata_next[WIDTH-1:0] = status_reg;
        ADDR_EDGE_SEL: rdata_next[WIDTH-1:0] = edge_sel_reg;
        default:       rdata_next = '0;
      endcase
    end
  end

  // Control registers, status, read data and interrupt all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_reg     <= '0;
      edge_sel_reg <= '0;
      status_reg   <= '0;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (wr_en && (bus_addr == ADDR_MASK)) begin
        mask_reg <= wr_bits;
      end
      if (wr_en && (bus_addr == ADDR_EDGE_SEL)) begin
        edge_sel_reg <= wr_bits;
      end
      status_reg <= status_next;
      rdata_reg  <= rdata_next;
      irq_reg    <= |(status_reg & mask_reg);
    end
  end

  assign bus_rdata = rdata_reg;
  assign irq       = irq_reg;

endmodule

// File: tb/tb_gpio_input_port.sv
// Testbench for gpio_input_port. Stimulus pushes expected values into queues; a monitor
// on the falling edge pops read responses as they appear and checks timed irq/rdata
// expectations on their due cycle.
module tb_gpio_input_port;

  localparam int WIDTH = 8;
`ifdef DEBOUNCE_EN
  localparam int FL = 16;
`else
  localparam int FL = 0;
`endif
  localparam int SETTLE = FL + 6;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;
  localparam logic [1:0] A_ESEL = 2'd3;

  localparam int K_READ  = 0;
  localparam int K_IRQ   = 1;
  localparam int K_RDATA = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pins;
  logic             bus_sel;
  logic [1:0]       bus_addr;
  logic             bus_we;
  logic             bus_rd;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             irq;

  always #5 clk = ~clk;

  gpio_input_port #(.WIDTH(WIDTH), .DEB_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .pins      (pins),
    .bus_sel   (bus_sel),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .irq       (irq)
  );

  typedef struct {
    string       name;
    int          kind;
    int          due;
    logic [31:0] exp;
  } chk_t;

  chk_t rd_q[$];
  chk_t at_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic rd_valid_q = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%08h", name, act);
    end
  endfunction

  // Cycle count and read-response tracking, derived from the bench's own stimulus.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    rd_valid_q <= bus_sel & bus_rd & ~reset;
  end

  // Monitor: compare read responses in order and timed expectations on their cycle.
  always @(negedge clk) begin
    chk_t e;
    if (rd_valid_q) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read actual=0x%08h required=no_response", bus_rdata);
      end else begin
        e = rd_q.pop_front();
        check(e.name, bus_rdata, e.exp);
      end
    end
    for (int i = at_q.size() - 1; i >= 0; i--) begin
      if (at_q[i].due == cyc) begin
        e = at_q[i];
        if (e.kind == K_IRQ) check(e.name, {31'b0, irq}, e.exp);
        else                 check(e.name, bus_rdata, e.exp);
        at_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (SETTLE) tick();
  endtask

  task automatic expect_at(input int kind, input int due, input logic [31:0] exp,
                           input string name);
    chk_t e;
    e.name = name; e.kind = kind; e.due = due; e.exp = exp;
    at_q.push_back(e);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    chk_t e;
    e.name = name; e.kind = K_READ; e.due = 0; e.exp = exp;
    rd_q.push_back(e);
    bus_sel = 1'b1; bus_rd = 1'b1; bus_addr = a;
    tick();
    bus_sel = 1'b0; bus_rd = 1'b0;
  endtask

  initial begin
    int n;
    chk_t e;
    reset = 1'b1; pins = '0; bus_sel = 1'b0; bus_addr = 2'd0;
    bus_we = 1'b0; bus_rd = 1'b0; bus_wdata = '0;
    #1;

    // Reset held 3 cycles with pins high and bus traffic.
    pins = 8'hFF; bus_sel = 1'b1; bus_we = 1'b1; bus_rd = 1'b1;
    bus_addr = A_MASK; bus_wdata = 32'hFFFF_FFFF;
    tick(); bus_addr = A_ESEL; tick(); bus_addr = A_STAT; tick();
    expect_at(K_RDATA, cyc, 32'h0, "reset_rdata");
    expect_at(K_IRQ, cyc, 32'h0, "reset_irq");
    bus_sel = 1'b0; bus_we = 1'b0; bus_rd = 1'b0;
    reset = 1'b0;
    do_read(A_STAT, 32'h0, "status_after_release");
    do_read(A_MASK, 32'h0, "mask_write_during_reset");
    do_read(A_ESEL, 32'h0, "esel_write_during_reset");
    settle();
    do_read(A_STAT, 32'hFF, "held_high_rise_events");
    pins = 8'h00;
    settle();
    do_write(A_STAT, 32'hFF);
    do_read(A_STAT, 32'h0, "status_w1c_all");

    // Rising edge on pin0 to STATUS and irq with exact latency.
    do_write(A_MASK, 32'h01);
    n = cyc;
    pins = 8'h01;
    expect_at(K_IRQ, n + 3 + FL, 32'h0, "irq_before_latency");
    expect_at(K_IRQ, n + 4 + FL, 32'h1, "irq_rise");
    repeat (FL + 2) tick();
    do_read(A_STAT, 32'h00, "status_before_latency");
    do_read(A_STAT, 32'h01, "status_rise");
    tick();
    n = cyc;
    expect_at(K_IRQ, n + 1, 32'h1, "irq_held_at_w1c");
    expect_at(K_IRQ, n + 2, 32'h0, "irq_cleared");
    do_write(A_STAT, 32'h01);
    tick(); tick();

    // Falling-edge select on pin2 and clear/set collision.
    do_write(A_ESEL, 32'h04);
    pins = 8'h05;
    settle();
    do_read(A_STAT, 32'h00, "rise_ignored_fall_sel");
    pins = 8'h01;
    settle();
    do_read(A_STAT, 32'h04, "fall_event");
    expect_at(K_IRQ, cyc, 32'h0, "irq_masked_bit2");
    do_write(A_STAT, 32'h00);
    do_read(A_STAT, 32'h04, "w1c_zero_noop");
    pins = 8'h05;
    settle();
    n = cyc;
    pins = 8'h01;
    repeat (FL + 2) tick();
    do_write(A_STAT, 32'h04);
    do_read(A_STAT, 32'h04, "collision_set_wins");
    do_write(A_STAT, 32'h04);
    do_read(A_STAT, 32'h00, "w1c_bit2");

`ifdef DEBOUNCE_EN
    // Debounce: short pulse discarded, stable change follows 16 cycles after sync2.
    pins = 8'h03;
    repeat (10) tick();
    pins = 8'h01;
    settle();
    do_read(A_DATA, 32'h01, "deb_glitch_data");
    do_read(A_STAT, 32'h00, "deb_glitch_status");
    n = cyc;
    pins = 8'h03;
    repeat (FL + 1) tick();
    do_read(A_DATA, 32'h01, "deb_data_before");
    do_read(A_DATA, 32'h03, "deb_data_after");
    settle();
    pins = 8'h01;
    settle();
    do_write(A_STAT, 32'hFF);
`endif

    // Readback paths.
    pins = 8'hA5;
    settle();
    do_read(A_DATA, 32'h0000_00A5, "data_readback");
    do_read(A_STAT, 32'h0000_00A0, "status_multi_rise");
    do_write(A_DATA, 32'h0);
    do_read(A_DATA, 32'h0000_00A5, "data_read_only");
    do_write(A_MASK, 32'hFFFF_FFFF);
    do_read(A_MASK, 32'h0000_00FF, "mask_width_limit");
    e.name = "rd_we_prewrite"; e.kind = K_READ; e.due = 0; e.exp = 32'hFF;
    rd_q.push_back(e);
    bus_sel = 1'b1; bus_we = 1'b1; bus_rd = 1'b1; bus_addr = A_MASK; bus_wdata = 32'h0F;
    tick();
    bus_sel = 1'b0; bus_we = 1'b0; bus_rd = 1'b0;
    do_read(A_MASK, 32'h0F, "mask_after_write");
    do_read(A_ESEL, 32'h04, "edge_sel_readback");

    // Reset pulse mid-operation with pending status and irq.
    do_write(A_ESEL, 32'h00);
    pins = 8'h00;
    settle();
    do_write(A_STAT, 32'hFF);
    do_read(A_STAT, 32'h00, "status_cleared");
    pins = 8'h03;
    settle();
    do_read(A_STAT, 32'h03, "status_03");
    expect_at(K_IRQ, cyc, 32'h1, "irq_before_reset");
    n = cyc;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_at(K_IRQ, n + 1, 32'h0, "irq_after_reset_pulse");
    expect_at(K_RDATA, n + 1, 32'h0, "rdata_after_reset_pulse");
    do_read(A_STAT, 32'h0, "status_after_reset_pulse");
    do_read(A_MASK, 32'h0, "mask_after_reset_pulse");
    settle();
    do_read(A_STAT, 32'h03, "held_pins_event_after_pulse");
    repeat (3) tick();

    if (rd_q.size() != 0 || at_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL pending_checks actual=%0d required=0", rd_q.size() + at_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
